// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 16x2 driver (8-bit, write-only): init, OFF/UPDATE/SHOW refreshes, done_show pulse.
// Define LCD_SIGNED_EN to render data_addr as signed two's complement (sign '+'/'-').
module lcd_hd44780_ctrl #(
  parameter int PWR_CYC = 750000,
  parameter int EN_CYC  = 25,
  parameter int CMD_CYC = 2000,
  parameter int CLR_CYC = 82000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  operation,
  input  logic [2:0]  opcode,
  input  logic [3:0]  addr,
  input  logic [15:0] data_addr,
  output logic        EN,
  output logic        RW,
  output logic        RS,
  output logic [7:0]  data,
  output logic        done_show
);
  localparam int CW = $clog2(PWR_CYC + CLR_CYC + CMD_CYC + EN_CYC + 2);
  localparam logic [1:0] OP_OFF  = 2'd0;
  localparam logic [1:0] OP_SHOW = 2'd2;
  localparam logic [1:0] OP_NONE = 2'd3;

  typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, OFF_CMD, CONV, DISP_ON, LINE1, LINE2} state_e;
  typedef enum logic [1:0] {B_SETUP, B_STROBE, B_WAIT} bst_e;

  state_e        state_q, state_d;
  bst_e          bst_q, bst_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    idx_q, idx_d;
  logic [1:0]    last_op_q, last_op_d;
  logic          off_q, off_d;
  logic [2:0]    opc_q, opc_d;
  logic [3:0]    addr_q, addr_d;
  logic [15:0]   bin_q, bin_d;
  logic [19:0]   bcd_q, bcd_d;
  logic          en_q, en_d, rs_q, rs_d, done_q, done_d;
  logic [7:0]    data_q, data_d;
  logic [15:0]   mag;
  logic [7:0]    sign_ch;
  logic          byte_done, sending_d, byte_rs;
  logic [7:0]    byte_val;
  logic [CW-1:0] wait_last;

`ifdef LCD_SIGNED_EN
  logic neg_q, neg_d;
  assign mag     = data_addr[15] ? (~data_addr + 16'd1) : data_addr;
  assign sign_ch = neg_q ? 8'h2D : 8'h2B;
`else
  assign mag     = data_addr;
  assign sign_ch = 8'h20;
`endif

  // One double-dabble iteration: add-3 on every BCD digit >= 5, then shift left by one.
  function automatic logic [35:0] dd_step(input logic [19:0] bcd, input logic [15:0] bin);
    logic [19:0] adj;
    for (int i = 0; i < 5; i++)
      adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    return {adj[18:0], bin, 1'b0};
  endfunction

  assign wait_last = (data_q == 8'h01 && !rs_q) ? CW'(CLR_CYC - 1) : CW'(CMD_CYC - 1);

  always_comb begin
    state_d   = state_q;
    bst_d     = bst_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    last_op_d = last_op_q;
    off_d     = off_q;
    opc_d     = opc_q;
    addr_d    = addr_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
    byte_done = 1'b0;
`ifdef LCD_SIGNED_EN
    neg_d     = neg_q;
`endif
    unique case (state_q)
      PWR_WAIT: begin
        if (cnt_q == CW'(PWR_CYC - 1)) begin
          state_d = INIT;
          cnt_d   = '0;
          idx_d   = '0;
          bst_d   = B_SETUP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      IDLE: begin
        if (operation != last_op_q && operation != OP_NONE) begin
          last_op_d = operation;
          opc_d     = opcode;
          addr_d    = addr;
          bin_d     = mag;
          bcd_d     = '0;
`ifdef LCD_SIGNED_EN
          neg_d     = data_addr[15];
`endif
          cnt_d     = '0;
          idx_d     = '0;
          bst_d     = B_SETUP;
          state_d   = (operation == OP_OFF) ? OFF_CMD : CONV;
        end
      end
      CONV: begin
        {bcd_d, bin_d} = dd_step(bcd_q, bin_q);
        if (cnt_q == CW'(15)) begin
          cnt_d   = '0;
          idx_d   = '0;
          bst_d   = B_SETUP;
          state_d = off_q ? DISP_ON : LINE1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        unique case (bst_q)
          B_SETUP: begin
            bst_d = B_STROBE;
            cnt_d = '0;
          end
          B_STROBE: begin
            if (cnt_q == CW'(EN_CYC - 1)) begin
              bst_d = B_WAIT;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          default: begin
            if (cnt_q == wait_last) byte_done = 1'b1;
            else cnt_d = cnt_q + CW'(1);
          end
        endcase
        // Next byte's SETUP follows the last WAIT cycle directly, keeping bytes back-to-back.
        if (byte_done) begin
          cnt_d = '0;
          bst_d = B_SETUP;
          idx_d = idx_q + 5'd1;
          unique case (state_q)
            INIT: if (idx_q == 5'd6) begin
              state_d = IDLE;
              idx_d   = '0;
            end
            OFF_CMD: begin
              state_d = IDLE;
              off_d   = 1'b1;
              idx_d   = '0;
            end
            DISP_ON: begin
              state_d = LINE1;
              off_d   = 1'b0;
              idx_d   = '0;
            end
            LINE1: if (idx_q == 5'd16) begin
              idx_d   = '0;
              state_d = (last_op_q == OP_SHOW) ? LINE2 : IDLE;
            end
            LINE2: if (idx_q == 5'd16) begin
              idx_d   = '0;
              state_d = IDLE;
              done_d  = 1'b1;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  // Byte to present for (state_d, idx_d); idx 0 of a line is its DDRAM address command.
  logic [55:0] mnem, mnem_sh;
  logic [19:0] dsh;
  logic [3:0]  li;
  logic [1:0]  k;
  logic [2:0]  j;

  always_comb begin
    byte_rs  = 1'b0;
    byte_val = 8'h00;
    li       = 4'(idx_d - 5'd1);
    k        = li[1:0] - 2'd1;
    j        = 3'(li - 4'd5);
    unique case (opc_q)
      3'd0: mnem = "LOAD   ";
      3'd1: mnem = "ADD    ";
      3'd2: mnem = "ADDI   ";
      3'd3: mnem = "SUB    ";
      3'd4: mnem = "SUBI   ";
      3'd5: mnem = "MUL    ";
      3'd6: mnem = "CLEAR  ";
      default: mnem = "DISPLAY";
    endcase
    mnem_sh = mnem << {li, 3'b000};
    dsh     = bcd_q << {j, 2'b00};
    unique case (state_d)
      INIT: begin
        unique case (idx_d)
          5'd0, 5'd1, 5'd2: byte_val = 8'h38;
          5'd3:             byte_val = 8'h08;
          5'd4:             byte_val = 8'h01;
          5'd5:             byte_val = 8'h06;
          default:          byte_val = 8'h0C;
        endcase
      end
      OFF_CMD: byte_val = 8'h08;
      DISP_ON: byte_val = 8'h0C;
      LINE1: begin
        if (idx_d == 5'd0) begin
          byte_val = 8'h80;
        end else begin
          byte_rs = 1'b1;
          if (li < 4'd7)                    byte_val = mnem_sh[55:48];
          else if (li == 4'd8)              byte_val = 8'h5B;
          else if (li >= 4'd9 && li <= 4'd12) byte_val = addr_q[2'd3 - k] ? 8'h31 : 8'h30;
          else if (li == 4'd13)             byte_val = 8'h5D;
          else                              byte_val = 8'h20;
        end
      end
      LINE2: begin
        if (idx_d == 5'd0) begin
          byte_val = 8'hC0;
        end else begin
          byte_rs = 1'b1;
          unique case (li)
            4'd0: byte_val = 8'h56;
            4'd1: byte_val = 8'h41;
            4'd2: byte_val = 8'h4C;
            4'd3: byte_val = 8'h3A;
            4'd4: byte_val = sign_ch;
            4'd5, 4'd6, 4'd7, 4'd8, 4'd9: byte_val = {4'h3, dsh[19:16]};
            default: byte_val = 8'h20;
          endcase
        end
      end
      default: ;
    endcase
  end

  assign sending_d = state_d inside {INIT, OFF_CMD, DISP_ON, LINE1, LINE2};

  always_comb begin
    en_d   = 1'b0;
    rs_d   = rs_q;
    data_d = data_q;
    if (sending_d) begin
      en_d = (bst_d == B_STROBE);
      if (bst_d == B_SETUP) begin
        rs_d   = byte_rs;
        data_d = byte_val;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= PWR_WAIT;
      bst_q     <= B_SETUP;
      cnt_q     <= '0;
      idx_q     <= '0;
      last_op_q <= OP_OFF;
      off_q     <= 1'b0;
      opc_q     <= '0;
      addr_q    <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      en_q      <= 1'b0;
      rs_q      <= 1'b0;
      data_q    <= 8'h00;
      done_q    <= 1'b0;
`ifdef LCD_SIGNED_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bst_q     <= bst_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      last_op_q <= last_op_d;
      off_q     <= off_d;
      opc_q     <= opc_d;
      addr_q    <= addr_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      en_q      <= en_d;
      rs_q      <= rs_d;
      data_q    <= data_d;
      done_q    <= done_d;
`ifdef LCD_SIGNED_EN
      neg_q     <= neg_d;
`endif
    end
  end

  assign EN        = en_q;
  assign RW        = 1'b0;
  assign RS        = rs_q;
  assign data      = data_q;
  assign done_show = done_q;
endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Bench for lcd_hd44780_ctrl: byte stream and timing compared against a string-level model of the panel traffic.
module tb_lcd_hd44780_ctrl;
  localparam int PWR = 20, ENC = 2, CMDC = 4, CLRC = 10;

  logic        clk = 1'b0, rst = 1'b1;
  logic [1:0]  operation = 2'd0;
  logic [2:0]  opcode = 3'd0;
  logic [3:0]  addr = 4'd0;
  logic [15:0] data_addr = 16'd0;
  logic        EN, RW, RS, done_show;
  logic [7:0]  data;

  always #5 clk = ~clk;

  lcd_hd44780_ctrl #(.PWR_CYC(PWR), .EN_CYC(ENC), .CMD_CYC(CMDC), .CLR_CYC(CLRC)) dut (
    .clk(clk), .rst(rst), .operation(operation), .opcode(opcode), .addr(addr),
    .data_addr(data_addr), .EN(EN), .RW(RW), .RS(RS), .data(data), .done_show(done_show)
  );

  typedef struct packed {logic bnd; logic rs; logic [7:0] d;} eb_t;
  eb_t        exp_q[$];
  logic [8:0] got_q[$];
  int         got_t[$];
  int checks = 0, errors = 0, cyc = 0, done_cnt = 0, exp_done = 0, last_acc = 0;
  bit off_flag = 1'b0;
  string names [8] = '{"LOAD", "ADD", "ADDI", "SUB", "SUBI", "MUL", "CLEAR", "DISPLAY"};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Monitor: one entry per EN rising edge, plus strobe width / hold / pulse checks.
  logic en_prev = 1'b0, done_prev = 1'b0;
  logic [8:0] cur = '0;
  int en_w = 0;
  always @(posedge clk) begin
    cyc++;
    #1;
    if (!rst) begin
      if (EN && !en_prev) begin
        got_q.push_back({RS, data});
        got_t.push_back(cyc);
        cur  = {RS, data};
        en_w = 1;
        chk("rw_low", RW, 0);
      end else if (EN) begin
        en_w++;
      end else if (en_prev) begin
        chk("en_width", en_w, ENC);
        chk("bus_hold", {RS, data}, cur);
      end
      if (done_show) begin
        done_cnt++;
        chk("done_single", done_prev, 0);
      end
    end
    en_prev   = EN;
    done_prev = done_show;
  end

  function automatic int period(input eb_t e);
    return (!e.rs && e.d == 8'h01) ? 1 + ENC + CLRC : 1 + ENC + CMDC;
  endfunction

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back({1'b0, 1'b1, s.getc(i)});
  endtask

  task automatic model_init();
    logic [7:0] seq [7];
    seq = '{8'h38, 8'h38, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
    last_acc = 0;
    off_flag = 1'b0;
    for (int i = 0; i < 7; i++) exp_q.push_back({(i == 0), 1'b0, seq[i]});
  endtask

  task automatic model_req(input logic [1:0] op, input logic [2:0] opc, input logic [3:0] ad,
                           input logic [15:0] da);
    string l1, l2, sg;
    int mag;
    if (op == 2'd3 || int'(op) == last_acc) return;
    last_acc = int'(op);
    if (op == 2'd0) begin
      exp_q.push_back({1'b1, 1'b0, 8'h08});
      off_flag = 1'b1;
      return;
    end
    if (off_flag) begin
      exp_q.push_back({1'b1, 1'b0, 8'h0C});
      exp_q.push_back({1'b0, 1'b0, 8'h80});
      off_flag = 1'b0;
    end else begin
      exp_q.push_back({1'b1, 1'b0, 8'h80});
    end
    l1 = names[opc];
    while (l1.len() < 7) l1 = {l1, " "};
    l1 = {l1, " [", $sformatf("%04b", ad), "]  "};
    push_str(l1);
    if (op == 2'd2) begin
      mag = int'(da);
      sg  = " ";
`ifdef LCD_SIGNED_EN
      sg = "+";
      if (da[15]) begin
        sg  = "-";
        mag = 65536 - int'(da);
      end
`endif
      l2 = {"VAL:", sg, $sformatf("%05d", mag), "      "};
      exp_q.push_back({1'b0, 1'b0, 8'hC0});
      push_str(l2);
      exp_done++;
    end
  endtask

  task automatic check_burst(input string tag, input int drv, input int lat);
    chk({tag, " count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s byte%0d", tag, i), got_q[i], {exp_q[i].rs, exp_q[i].d});
      if (i > 0 && !exp_q[i].bnd)
        chk($sformatf("%s gap%0d", tag, i), got_t[i] - got_t[i-1], period(exp_q[i-1]));
    end
    if (lat >= 0 && got_t.size() > 0) chk({tag, " latency"}, got_t[0] - drv, lat);
    chk({tag, " done_show"}, done_cnt, exp_done);
    got_q.delete();
    got_t.delete();
    exp_q.delete();
    done_cnt = 0;
    exp_done = 0;
  endtask

  task automatic do_req(input string tag, input logic [1:0] op, input logic [2:0] opc,
                        input logic [3:0] ad, input logic [15:0] da);
    int drv, lat;
    @(negedge clk);
    operation = op; opcode = opc; addr = ad; data_addr = da;
    drv = cyc;
    model_req(op, opc, ad, da);
    lat = (exp_q.size() == 0) ? -1 : ((op == 2'd0) ? 2 : 18);
    repeat (3) @(negedge clk);
    opcode = 3'($urandom); addr = 4'($urandom); data_addr = 16'($urandom);
    repeat (300) @(negedge clk);
    check_burst(tag, drv, lat);
  endtask

  initial begin
    int drv;
    logic [15:0] rd;
    repeat (2) @(negedge clk);
    chk("reset EN", EN, 0);
    chk("reset RW", RW, 0);
    chk("reset RS", RS, 0);
    chk("reset data", data, 0);
    chk("reset done_show", done_show, 0);

    rst = 1'b0;
    drv = cyc;
    model_init();
    repeat (120) @(negedge clk);
    check_burst("init", drv, PWR + 1);

    // SHOW with inputs disturbed mid-refresh and an operation glitch that returns before IDLE
    @(negedge clk);
    operation = 2'd2; opcode = 3'd1; addr = 4'b0101; data_addr = 16'd1234;
    drv = cyc;
    model_req(2'd2, 3'd1, 4'b0101, 16'd1234);
    repeat (5) @(negedge clk);
    opcode = 3'($urandom); addr = 4'($urandom); data_addr = 16'($urandom);
    repeat (40) @(negedge clk);
    operation = 2'd0;
    repeat (20) @(negedge clk);
    operation = 2'd2;
    repeat (260) @(negedge clk);
    check_burst("show1234", drv, 18);

    do_req("upd_ffff", 2'd1, 3'($urandom), 4'($urandom), 16'hFFFF);
    do_req("show_ffff", 2'd2, 3'($urandom), 4'($urandom), 16'hFFFF);
    do_req("off", 2'd0, 3'd0, 4'd0, 16'd0);
    do_req("off_again", 2'd0, 3'd3, 4'd3, 16'd3);
    do_req("upd_after_off", 2'd1, 3'd7, 4'b1001, 16'd7);
    do_req("show_8000", 2'd2, 3'd6, 4'b1110, 16'h8000);
    do_req("op3_ignored", 2'd3, 3'd2, 4'd2, 16'd2);
    for (int n = 0; n < 10; n++) begin
      rd = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      do_req($sformatf("rand%0d", n), 2'($urandom_range(0, 3)), 3'($urandom), 4'($urandom), rd);
    end

    // Request raised during INIT is held until IDLE
    @(negedge clk);
    rst = 1'b1; operation = 2'd0;
    @(negedge clk);
    rst = 1'b0;
    drv = cyc;
    model_init();
    repeat (30) @(negedge clk);
    operation = 2'd2; opcode = 3'd4; addr = 4'b0011; data_addr = 16'd65535;
    model_req(2'd2, 3'd4, 4'b0011, 16'd65535);
    repeat (350) @(negedge clk);
    check_burst("defer_init", drv, PWR + 1);

    // Reset during the 5th line-1 character of a SHOW
    do_req("upd_pre", 2'd1, 3'd5, 4'b1010, 16'd99);
    @(negedge clk);
    operation = 2'd2; opcode = 3'd3; addr = 4'b0110; data_addr = 16'd42;
    drv = cyc;
    model_req(2'd2, 3'd3, 4'b0110, 16'd42);
    for (int i = 0; i < 100 && got_q.size() < 6; i++) @(negedge clk);
    chk("reach 5th char", got_q.size(), 6);
    rst = 1'b1; operation = 2'd0;
    #1;
    chk("abort EN", EN, 0);
    chk("abort RS", RS, 0);
    chk("abort data", data, 0);
    chk("abort done_show", done_show, 0);
    exp_q = exp_q[0:5];
    exp_done = 0;
    check_burst("abort", drv, 18);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drv = cyc;
    model_init();
    repeat (150) @(negedge clk);
    check_burst("reinit", drv, PWR + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_hd44780_ctrl.md
# lcd_hd44780_ctrl

- Downstream display stage of the mini CPU: drives a 16x2 HD44780-compatible LCD in 8-bit write-only mode.
- The CPU controller issues a display operation plus the current opcode/address switches and the RAM word read back.
- The block initialises the panel, renders both text lines and pulses `done_show` when a SHOW refresh completes.
- Bytes are written in a fixed order with a fixed per-byte cycle budget, so the bench can predict every LCD write.

## Interface
- `PWR_CYC`, 750000: power-on wait before init (15 ms @ 50 MHz).
- `EN_CYC`, 25: EN high width in cycles.
- `CMD_CYC`, 2000: post-byte wait for normal commands and data (40 us).
- `CLR_CYC`, 82000: post-byte wait after command 0x01 (1.64 ms).
- `clk  in  1`: system clock.
- `rst  in  1`: asynchronous, active-high reset.
- `operation  in  2`: request code. 0 = OFF, 1 = UPDATE, 2 = SHOW; 3 is ignored.
- `opcode  in  3`: CPU opcode shown as a mnemonic.
- `addr  in  4`: destination address shown in binary.
- `data_addr  in  16`: RAM word shown in decimal.
- `EN  out  1`: LCD enable strobe.
- `RW  out  1`: LCD read/write select; constant 0.
- `RS  out  1`: LCD register select. 0 = command, 1 = data.
- `data  out  8`: LCD data bus.
- `done_show  out  1`: 1-cycle pulse when a SHOW refresh completes.

## Operation
- Reset values:
  - `EN=0`, `RW=0`, `RS=0`, `data=8'h00`, `done_show=0`.
  - Last-accepted operation = OFF.
  - Main state = PWR_WAIT.
- Main FSM states: PWR_WAIT → INIT (7 commands) → IDLE → {OFF_CMD | CONV → LINE1 → LINE2 → DONE}.
  - INIT command order: 0x38, 0x38, 0x38, 0x08, 0x01, 0x06, 0x0C.
- Request acceptance:
  - `operation` is sampled only in IDLE.
  - A request is accepted when `operation` differs from the last-accepted value and is not 3.
  - Changes made while the block is busy are evaluated on the return to IDLE.
  - A value that changes and then returns to the last-accepted value before IDLE is lost; this is required behaviour.
- Latching: `opcode`, `addr` and `data_addr` are latched in the acceptance cycle; later input changes do not affect the refresh in progress.
- OFF: sends one command, 0x08. A display-off flag is set.
- UPDATE: sends 0x0C first if the display-off flag is set, clearing the flag. Then sends 0x80 followed by the 16 line-1 characters. No `done_show`.
- SHOW: same as UPDATE, then 0xC0 followed by the 16 line-2 characters, then `done_show`.
- Line 1 (16 chars): mnemonic padded with spaces to 7 chars, then space, `[`, addr bits MSB first as '0'/'1', `]`, two spaces.
  - Mnemonics for opcodes 0..7: LOAD, ADD, ADDI, SUB, SUBI, MUL, CLEAR, DISPLAY.
- Line 2 (16 chars): "VAL:", sign char, 5 decimal digits with leading zeros kept, 6 spaces.
- CONV: sequential double-dabble over 16 cycles on the magnitude, starting the cycle after acceptance. It completes before the first LINE1 byte.
- Signed rendering: magnitude = two's-complement negation when bit 15 is set. 0x8000 renders as magnitude 32768.

## Timing
- Byte sub-FSM: SETUP → STROBE → WAIT.
  - SETUP (1 cycle): `RS` and `data` are driven.
  - STROBE: `EN=1` for exactly `EN_CYC` cycles.
  - WAIT: `EN=0` for `CMD_CYC` cycles, or `CLR_CYC` cycles after 0x01.
- `RS` and `data` are held stable from SETUP until the end of WAIT.
- Byte period = 1 + `EN_CYC` + `CMD_CYC` cycles (`CLR_CYC` for 0x01). Bytes are back-to-back with no gap.
- `done_show` asserts for one cycle, the cycle after the WAIT of the last line-2 byte. IDLE is reached in that same cycle.
- Acceptance-to-first-SETUP latency: 17 cycles (1 acceptance cycle + 16 CONV cycles). This applies to UPDATE and SHOW. OFF enters SETUP the cycle after acceptance.
- Reset asserted mid-operation:
  - All outputs return to their reset values immediately (asynchronous).
  - Any partial byte is abandoned.
  - The full PWR_WAIT and INIT sequence reruns.
  - No `done_show` is produced for the interrupted request.

## Configuration
- `LCD_SIGNED_EN` defined: `data_addr` is treated as signed; the sign char is '-' when negative, otherwise '+'.
- `LCD_SIGNED_EN` undefined: `data_addr` is treated as unsigned (0..65535); the sign char is always a space; no negation logic.

## Test plan
Bench parameters for all scenarios: `PWR_CYC=20`, `EN_CYC=2`, `CMD_CYC=4`, `CLR_CYC=10`.
- Reset release with `operation=0` → after 20 cycles, exactly 7 EN pulses with RS=0 and bytes 0x38, 0x38, 0x38, 0x08, 0x01, 0x06, 0x0C. The gap after 0x01 is 10 cycles. No further traffic.
- `operation` 0→2, `opcode=1`, `addr=4'b0101`, `data_addr=16'd1234` → bytes:
  - 0x08 is not sent; 0x0C is not sent.
  - 0x80, then "ADD     [0101]  ".
  - 0xC0, then "VAL:+01234      ".
  - One `done_show` pulse.
- SHOW with `data_addr=16'hFFFF` → line 2 "VAL:-00001      " with the macro; "VAL: 65535      " without it.
- SHOW with `data_addr=16'h8000` and the macro defined → "VAL:-32768      ".
- Request sequence:
  - `operation`→0 → a single 0x08 only.
  - Then `operation`→1 → 0x0C, then 0x80 + line 1, no line 2, no `done_show`.
- Timing corner cases:
  - `operation`=2 asserted during INIT → deferred until INIT completes, then the refresh runs.
  - `rst` pulsed during the 5th line-1 character → EN, RS and data are 0 immediately; INIT reruns; no `done_show`.
